prefetch_slot_ctrl: RTL
=======================

// Module: prefetch_slot_ctrl
// PURPOSE
//  In-order-retire, out-of-order-complete slot tracker for the prefetcher's cyclic entry array.
//  Allocates slots at tail, marks slots done on completion, and retires from head over a valid/ready handshake.
//  Publishes a per-slot occupancy mask (cyclic head..tail range) for prefetch-queue lookup logic.
// PARAMETERS
//  LOG_DEPTH  3          log2 of slot count
//  DEPTH      1<<LOG_DEPTH  slot count (derived; do not override)
// PORTS
//  clk         in   1            single clock, rising edge
//  resetN      in   1            asynchronous, active-low reset
//  alloc_req   in   1            request a new slot
//  alloc_gnt   out  1            slot granted this cycle (comb)
//  alloc_idx   out  LOG_DEPTH    granted slot index (= tail)
//  cmpl_valid  in   1            completion strobe
//  cmpl_idx    in   LOG_DEPTH    slot being completed
//  cmpl_err    out  1            registered pulse: completion hit an unoccupied slot
//  ret_valid   out  1            head slot occupied and done
//  ret_idx     out  LOG_DEPTH    head index
//  ret_ready   in   1            consumer accepts retire
//  valid_mask  out  DEPTH        bit i = slot i occupied
//  count       out  LOG_DEPTH+1  occupied slots, 0..DEPTH
//  full, empty out  1            count==DEPTH / count==0
//  flush       in   1            present only with PF_SLOT_FLUSH_EN
// BEHAVIOUR
//  Reset: head=tail=0, count=0, done[]=0, state=RUN; outputs: alloc_gnt=0, ret_valid=0, cmpl_err=0,
//   valid_mask=0, count=0, empty=1, full=0.
//  alloc_gnt = alloc_req & ~full & state==RUN (full from current registers; retire same cycle does NOT free space).
//  On gnt: done[tail]<=0, tail<=tail+1 mod DEPTH.
//  Completion: if slot cmpl_idx occupied (valid_mask bit set at that cycle) -> done[cmpl_idx]<=1; else drop, cmpl_err<=1 for one cycle.
//   Completion to slot being allocated same cycle is unoccupied -> dropped + cmpl_err.
//   Completion of already-done slot: no effect, no error.
//  ret_valid = ~empty & done[head] & state==RUN; completion->ret_valid latency = 1 cycle.
//  On ret_valid & ret_ready: head<=head+1 mod DEPTH, done[head]<=0. ret_valid may drop only on retire; ret_idx stable while ret_valid & ~ret_ready.
//  count <= count + gnt - retire; alloc and retire same cycle -> count unchanged.
//  valid_mask = empty ? 0 : cyclic mask head..tail-1; head==tail with full -> all ones; wraps when tail<head.
//  Pointers wrap silently; no overflow/underflow possible by construction.
//  FSM: RUN (normal), FLUSH (see CONFIGURATION). Without macro, FSM is RUN-only.
//  Reset mid-operation: all state cleared asynchronously; in-flight completions lost.
// CONFIGURATION
//  PF_SLOT_FLUSH_EN defined: flush port exists. flush=1 in RUN -> FLUSH next cycle; in FLUSH alloc_gnt=0,
//   ret_valid=0, completions ignored (no cmpl_err); one cycle later head=tail=0, count=0, done[]=0, back to RUN.
//   flush held high keeps FSM in FLUSH.
//  Undefined: no flush port, no FLUSH state; behaviour otherwise identical.
// STRUCTURE
//  Package pf_slot_pkg: slot_idx_t (logic[LOG_DEPTH-1:0]), slot_cnt_t, slot_state_e {RUN, FLUSH}.
//  Sub-module slot_range_mask: combinational cyclic head..tail mask generator (head==tail -> all ones).
//  Top holds pointers, count, done vector, FSM, handshake logic.
// TESTING (LOG_DEPTH=3)
//  Reset, then alloc_req=1 for 8 cycles -> idx 0..7, full=1 after 8th, 9th req gnt=0, valid_mask=8'hFF.
//  Alloc 3, complete idx 2 then 0 -> ret_valid next cycle at idx0; retire 0; idx1 not done -> ret_valid=0.
//  Head=6, alloc 4 (tail wraps to 2) -> valid_mask bits 6,7,0,1 set, count=4.
//  Full, alloc_req & retire same cycle -> gnt=0, count 8->7; next cycle gnt=1, count=8.
//  cmpl_idx=5 while empty -> cmpl_err pulse 1 cycle, done unchanged, ret_valid=0.
//  PF_SLOT_FLUSH_EN: 5 occupied, flush 1 cycle -> next cycle gnt=0; cycle after count=0, empty=1, mask=0.

Source files
------------

// File: rtl/pf_slot_pkg.sv
// Shared types for the prefetch slot tracker.
// Optional feature macro used by the top: PF_SLOT_FLUSH_EN (flush port + FLUSH state).
package pf_slot_pkg;

  localparam int PF_LOG_DEPTH = 3;
  localparam int PF_DEPTH     = 1 << PF_LOG_DEPTH;

  typedef logic [PF_LOG_DEPTH-1:0] slot_idx_t;
  typedef logic [PF_LOG_DEPTH:0]   slot_cnt_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } slot_state_e;

endpackage

// File: rtl/slot_range_mask.sv
// Combinational cyclic range mask: bit i is set when slot i lies in head..tail-1
// (wrapping). head==tail yields all ones; the caller qualifies with its empty flag.
module slot_range_mask #(
  parameter  int LOG_DEPTH = 3,
  localparam int DEPTH     = 1 << LOG_DEPTH
) (
  input  logic [LOG_DEPTH-1:0] head,
  input  logic [LOG_DEPTH-1:0] tail,
  output logic [DEPTH-1:0]     mask
);

  logic [LOG_DEPTH-1:0] span;

  // Occupied span length modulo DEPTH.
  assign span = tail - head;

  for (genvar i = 0; i < DEPTH; i++) begin : g_bit
    logic [LOG_DEPTH-1:0] off;
    // Distance of slot i from head, modulo DEPTH.
    assign off     = LOG_DEPTH'(i) - head;
    assign mask[i] = (head == tail) | (off < span);
  end

endmodule

// File: rtl/prefetch_slot_ctrl.sv
// In-order-retire, out-of-order-complete slot tracker for the prefetcher's
// cyclic entry array. Slots are allocated at tail, marked done on completion,
// and retired from head.
// Optional feature: define PF_SLOT_FLUSH_EN to add the flush port and FLUSH state.
//
// Retire handshake: ret_valid is asserted while the head slot is occupied and
// done; a transfer happens on a cycle where ret_valid & ret_ready are both high.
// ret_valid only drops after a transfer, and ret_idx holds steady while
// ret_valid is high and ret_ready is low.
module prefetch_slot_ctrl
  import pf_slot_pkg::*;
#(
  parameter  int LOG_DEPTH = PF_LOG_DEPTH,
  localparam int DEPTH     = 1 << LOG_DEPTH
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [LOG_DEPTH-1:0] alloc_idx,
  input  logic                 cmpl_valid,
  input  logic [LOG_DEPTH-1:0] cmpl_idx,
  output logic                 cmpl_err,
  output logic                 ret_valid,
  output logic [LOG_DEPTH-1:0] ret_idx,
  input  logic                 ret_ready,
  output logic [DEPTH-1:0]     valid_mask,
  output logic [LOG_DEPTH:0]   count,
  output logic                 full,
  output logic                 empty,
`ifdef PF_SLOT_FLUSH_EN
  input  logic                 flush,
`endif
  output logic                 fsm_state
);

  logic [LOG_DEPTH-1:0] head;
  logic [LOG_DEPTH-1:0] tail;
  logic [LOG_DEPTH:0]   count_q;
  logic [DEPTH-1:0]     done;
  logic [DEPTH-1:0]     range_mask;
  logic                 cmpl_err_q;
  logic                 run;
  logic                 retire;
  slot_state_e          state;
  slot_state_e          state_next;

  slot_range_mask #(.LOG_DEPTH(LOG_DEPTH)) u_range_mask (
    .head (head),
    .tail (tail),
    .mask (range_mask)
  );

  assign run        = (state == RUN);
  assign full       = (count_q == (LOG_DEPTH+1)'(DEPTH));
  assign empty      = (count_q == '0);
  // Full is taken from registered count: a same-cycle retire frees nothing yet.
  assign alloc_gnt  = alloc_req & ~full & run;
  assign alloc_idx  = tail;
  assign ret_valid  = ~empty & done[head] & run;
  assign ret_idx    = head;
  assign retire     = ret_valid & ret_ready;
  assign valid_mask = empty ? '0 : range_mask;
  assign count      = count_q;
  assign cmpl_err   = cmpl_err_q;
  assign fsm_state  = (state == FLUSH);

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= RUN;
    else         state <= state_next;
  end

  // FSM next state: FLUSH lasts while flush is held, then returns to RUN.
  always_comb begin
    state_next = state;
`ifdef PF_SLOT_FLUSH_EN
    case (state)
      RUN:     if (flush)  state_next = FLUSH;
      FLUSH:   if (!flush) state_next = RUN;
      default:             state_next = RUN;
    endcase
`else
    state_next = RUN;
`endif
  end

  // Pointers and occupancy count; a FLUSH cycle clears them.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (!run) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (alloc_gnt) tail <= tail + 1'b1;
      if (retire)    head <= head + 1'b1;
      count_q <= count_q + (LOG_DEPTH+1)'(alloc_gnt) - (LOG_DEPTH+1)'(retire);
    end
  end

  // Done flags and completion error pulse. Completions only land on occupied
  // slots; the slot being allocated this cycle is not yet occupied.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      done       <= '0;
      cmpl_err_q <= 1'b0;
    end else begin
      cmpl_err_q <= 1'b0;
      if (!run) begin
        done <= '0;
      end else begin
        if (cmpl_valid) begin
          if (valid_mask[cmpl_idx]) done[cmpl_idx] <= 1'b1;
          else                      cmpl_err_q     <= 1'b1;
        end
        if (retire)    done[head] <= 1'b0;
        if (alloc_gnt) done[tail] <= 1'b0;
      end
    end
  end

endmodule
